// File: rtl/pulse_ts_pkg.sv
// Shared types and entry layout for the pulse timestamper.
// An entry is packed as {time, index, period_ok}, with period_ok in the LSB.
package pulse_ts_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  localparam int unsigned TS_WIDTH_DEF  = 48;
  localparam int unsigned IDX_WIDTH_DEF = 16;

  localparam int unsigned OK_OFS  = 0;
  localparam int unsigned IDX_OFS = 1;

  function automatic int unsigned entry_width(input int unsigned ts_w, input int unsigned idx_w);
    return ts_w + idx_w + 1;
  endfunction

  function automatic int unsigned time_ofs(input int unsigned idx_w);
    return idx_w + 1;
  endfunction

  localparam int unsigned ENTRY_W_DEF = entry_width(TS_WIDTH_DEF, IDX_WIDTH_DEF);

endpackage

// File: rtl/pulse_timestamper_fifo.sv
// Small first-word-fall-through FIFO; head data is visible whenever o_valid is high.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module ts_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic             o_push_ok,
  output logic [WIDTH-1:0] o_data
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [AW:0]      r_count;
  logic             w_full;
  logic             w_pop;

  assign o_valid   = (r_count != '0);
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_pop     = i_pop & o_valid;
  assign o_push_ok = i_push & (~w_full | w_pop);
  assign o_data    = r_mem[r_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (o_push_ok) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({o_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pulse_timestamper.sv
// Tags each start pulse with time and sequence index, buffers entries in a FWFT FIFO,
// and tracks lock status from the measured inter-pulse period.
module pulse_timestamper
  import pulse_ts_pkg::*;
#(
  parameter int unsigned TS_WIDTH   = 48,
  parameter int unsigned IDX_WIDTH  = 16,
  parameter int unsigned PER_WIDTH  = 32,
  parameter int unsigned FIFO_AW    = 2,
  parameter int unsigned PERIOD_NOM = 200_000_000,
  parameter int unsigned PERIOD_TOL = 1000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_pulse,
  input  logic                 ovf_clear,
  output logic                 ts_valid,
  input  logic                 ts_ready,
  output logic [TS_WIDTH-1:0]  ts_time,
  output logic [IDX_WIDTH-1:0] ts_index,
  output logic                 ts_period_ok,
  output logic                 overflow,
  output logic                 locked,
  output logic [TS_WIDTH-1:0]  time_now
);

  localparam int unsigned ENTRY_W  = entry_width(TS_WIDTH, IDX_WIDTH);
  localparam int unsigned TIME_OFS = time_ofs(IDX_WIDTH);
  localparam longint unsigned PER_LIMIT = longint'(PERIOD_NOM) + longint'(PERIOD_TOL);

  if ((PER_LIMIT >> PER_WIDTH) != 0) begin : g_bad_period
    $error("PERIOD_NOM + PERIOD_TOL does not fit in PER_WIDTH bits");
  end

  localparam logic [PER_WIDTH-1:0] NOM = PER_WIDTH'(PERIOD_NOM);
  localparam logic [PER_WIDTH-1:0] TOL = PER_WIDTH'(PERIOD_TOL);
  localparam logic [PER_WIDTH-1:0] HI  = PER_WIDTH'(PER_LIMIT);

  logic [TS_WIDTH-1:0]  r_time;
  logic [PER_WIDTH-1:0] r_period;
  logic [IDX_WIDTH-1:0] r_index;
  logic                 r_first_seen;
  logic                 r_ovf;
  logic                 r_locked;
  lock_state_t          r_state;

  logic [PER_WIDTH-1:0] w_diff;
  logic                 w_ok;
  logic                 w_pop;
  logic                 w_push_ok;
  logic                 w_drop;
  logic [ENTRY_W-1:0]   w_entry;
  logic [ENTRY_W-1:0]   w_head;

  assign w_diff = (r_period >= NOM) ? (r_period - NOM) : (NOM - r_period);
  assign w_ok   = r_first_seen & (w_diff <= TOL);
  assign w_pop  = ts_valid & ts_ready;
  assign w_drop = start_pulse & ~w_push_ok;

  always_comb begin
    w_entry                           = '0;
    w_entry[OK_OFS]                   = w_ok;
    w_entry[IDX_OFS +: IDX_WIDTH]     = r_index;
    w_entry[TIME_OFS +: TS_WIDTH]     = r_time;
  end

  ts_fifo #(
    .WIDTH (ENTRY_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (start_pulse),
    .i_data    (w_entry),
    .i_pop     (w_pop),
    .o_valid   (ts_valid),
    .o_push_ok (w_push_ok),
    .o_data    (w_head)
  );

  assign ts_time      = w_head[TIME_OFS +: TS_WIDTH];
  assign ts_index     = w_head[IDX_OFS +: IDX_WIDTH];
  assign ts_period_ok = w_head[OK_OFS];
  assign overflow     = r_ovf;
  assign locked       = r_locked;
  assign time_now     = r_time;

  // Index advances on every pulse, so dropped entries show up as index gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_time       <= '0;
      r_period     <= '0;
      r_index      <= '0;
      r_first_seen <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_time <= r_time + 1'b1;
      if (start_pulse) begin
        r_period     <= PER_WIDTH'(1);
        r_index      <= r_index + 1'b1;
        r_first_seen <= 1'b1;
      end else if (r_period != '1) begin
        r_period <= r_period + 1'b1;
      end
      if (w_drop)         r_ovf <= 1'b1;
      else if (ovf_clear) r_ovf <= 1'b0;
    end
  end

  // A pulse takes priority over the missing-pulse timeout in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= UNLOCKED;
      r_locked <= 1'b0;
    end else if (start_pulse) begin
      case (r_state)
        UNLOCKED: if (w_ok) r_state <= ACQUIRE;
        ACQUIRE: begin
          if (w_ok) begin
            r_state  <= LOCKED;
            r_locked <= 1'b1;
          end else begin
            r_state <= UNLOCKED;
          end
        end
        LOCKED: begin
          if (!w_ok) begin
            r_state  <= UNLOCKED;
            r_locked <= 1'b0;
          end
        end
        default: begin
          r_state  <= UNLOCKED;
          r_locked <= 1'b0;
        end
      endcase
    end else if (r_state != UNLOCKED && r_period > HI) begin
      r_state  <= UNLOCKED;
      r_locked <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_timestamper.sv
// Bench for pulse_timestamper: queue-based reference model checked every cycle,
// plus directed scenarios pinned with literal expected entries.
module tb_pulse_timestamper;

  localparam int unsigned NOM = 100;
  localparam int unsigned TOL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_pulse = 1'b0;
  logic        ovf_clear = 1'b0;
  logic        ts_ready = 1'b0;
  logic        ts_valid;
  logic [47:0] ts_time;
  logic [15:0] ts_index;
  logic        ts_period_ok;
  logic        overflow;
  logic        locked;
  logic [47:0] time_now;

  pulse_timestamper #(
    .TS_WIDTH   (48),
    .IDX_WIDTH  (16),
    .PER_WIDTH  (32),
    .FIFO_AW    (2),
    .PERIOD_NOM (NOM),
    .PERIOD_TOL (TOL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_pulse  (start_pulse),
    .ovf_clear    (ovf_clear),
    .ts_valid     (ts_valid),
    .ts_ready     (ts_ready),
    .ts_time      (ts_time),
    .ts_index     (ts_index),
    .ts_period_ok (ts_period_ok),
    .overflow     (overflow),
    .locked       (locked),
    .time_now     (time_now)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] t;
    logic [15:0] idx;
    logic        ok;
  } ent_t;

  ent_t        mq[$];
  ent_t        popped[$];
  logic [47:0] m_time;
  longint      m_period;
  logic [15:0] m_idx;
  bit          m_first;
  bit          m_ovf;
  int          m_lock;   // 0 unlocked, 1 acquiring, 2 locked

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_time = '0; m_period = 0; m_idx = '0;
    m_first = 0; m_ovf = 0; m_lock = 0;
  endtask

  task automatic model_step();
    bit     pop, drop, ok;
    longint d;
    ent_t   e;
    pop  = (mq.size() > 0) && ts_ready;
    drop = 0;
    ok   = 0;
    e    = '{t: '0, idx: '0, ok: 1'b0};
    if (start_pulse) begin
      d  = m_period - longint'(NOM);
      if (d < 0) d = -d;
      ok = m_first && (d <= longint'(TOL));
      e  = '{t: m_time, idx: m_idx, ok: ok};
      if (mq.size() >= 4 && !pop) drop = 1;
      m_idx   = m_idx + 16'd1;
      m_first = 1;
    end
    if (pop) void'(mq.pop_front());
    if (start_pulse && !drop) mq.push_back(e);
    if (drop) m_ovf = 1;
    else if (ovf_clear) m_ovf = 0;
    if (start_pulse) begin
      if (m_lock == 0)      m_lock = ok ? 1 : 0;
      else if (m_lock == 1) m_lock = ok ? 2 : 0;
      else                  m_lock = ok ? 2 : 0;
    end else if (m_lock != 0 && m_period > longint'(NOM + TOL)) begin
      m_lock = 0;
    end
    if (start_pulse)                 m_period = 1;
    else if (m_period < 64'hFFFFFFFF) m_period = m_period + 1;
    m_time = m_time + 48'd1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("ts_valid", ts_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("ts_time",      ts_time,      mq[0].t);
        chk("ts_index",     ts_index,     mq[0].idx);
        chk("ts_period_ok", ts_period_ok, mq[0].ok);
      end
      chk("overflow", overflow, m_ovf);
      chk("locked",   locked,   m_lock == 2);
      chk("time_now", time_now, m_time);
      if (ts_valid && ts_ready) popped.push_back('{t: ts_time, idx: ts_index, ok: ts_period_ok});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    int guard = 0;
    while (m_time < 48'(n) && guard < 5000) begin
      tick();
      guard++;
    end
    if (guard >= 5000) chk("wait_budget", guard, 0);
  endtask

  task automatic pulse_at(input int n);
    wait_until(n);
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
  endtask

  task automatic pin(input string nm, input int k, input longint t, input int idx, input int ok);
    if (popped.size() <= k) chk({nm, "_present"}, popped.size(), k + 1);
    else begin
      chk({nm, "_time"},  popped[k].t,   t);
      chk({nm, "_index"}, popped[k].idx, idx);
      chk({nm, "_ok"},    popped[k].ok,  ok);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start_pulse = 1'b0; ts_ready = 1'b0; ovf_clear = 1'b0;
    tick();
    tick();
    chk("rst_valid", ts_valid, 0);
    chk("rst_time",  ts_time, 0);
    chk("rst_index", ts_index, 0);
    chk("rst_ok",    ts_period_ok, 0);
    chk("rst_ovf",   overflow, 0);
    chk("rst_lock",  locked, 0);
    chk("rst_now",   time_now, 0);
    popped.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    // Lock acquisition, then timeout unlock
    do_reset();
    ts_ready = 1'b1;
    pulse_at(10); pulse_at(110); pulse_at(210);
    wait_until(212); chk("s1_locked", locked, 1);
    wait_until(313); chk("s1_locked_313", locked, 1);
    wait_until(314); chk("s1_unlock_314", locked, 0);
    pin("s1_e0", 0, 10, 0, 0);
    pin("s1_e1", 1, 110, 1, 1);
    pin("s1_e2", 2, 210, 2, 1);

    // Early pulse while locked
    do_reset();
    ts_ready = 1'b1;
    pulse_at(10); pulse_at(110); pulse_at(210);
    wait_until(305); chk("s2_locked_305", locked, 1);
    start_pulse = 1'b1; tick(); start_pulse = 1'b0;
    chk("s2_unlock_306", locked, 0);
    wait_until(310);
    pin("s2_e3", 3, 305, 3, 0);

    // Tolerance edges and back-to-back pulses
    do_reset();
    ts_ready = 1'b1;
    pulse_at(10); pulse_at(108); pulse_at(210); pulse_at(307);
    pulse_at(410); pulse_at(510); pulse_at(511);
    wait_until(520);
    pin("s3_e0", 0, 10, 0, 0);
    pin("s3_p98", 1, 108, 1, 1);
    pin("s3_p102", 2, 210, 2, 1);
    pin("s3_p97", 3, 307, 3, 0);
    pin("s3_p103", 4, 410, 4, 0);
    pin("s3_p100", 5, 510, 5, 1);
    pin("s3_p1", 6, 511, 6, 0);

    // Overflow with stalled consumer
    do_reset();
    for (int i = 0; i < 6; i++) pulse_at(10 + 100 * i);
    wait_until(515);
    chk("s4_ovf", overflow, 1);
    chk("s4_head_idx", ts_index, 0);
    ts_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    ts_ready = 1'b0;
    pulse_at(610);
    ts_ready = 1'b1;
    wait_until(615);
    for (int i = 0; i < 4; i++) pin("s4_drain", i, 10 + 100 * i, i, (i == 0) ? 0 : 1);
    pin("s4_after", 4, 610, 6, 1);

    // Full with coincident pop; clear colliding with a drop
    do_reset();
    pulse_at(10); pulse_at(20); pulse_at(30); pulse_at(40);
    wait_until(50);
    ts_ready = 1'b1; start_pulse = 1'b1;
    tick();
    ts_ready = 1'b0; start_pulse = 1'b0;
    chk("s5_no_ovf", overflow, 0);
    chk("s5_head_idx", ts_index, 1);
    wait_until(60);
    start_pulse = 1'b1; ovf_clear = 1'b1;
    tick();
    start_pulse = 1'b0; ovf_clear = 1'b0;
    chk("s5_ovf_set_wins", overflow, 1);
    tick();
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    chk("s5_ovf_cleared", overflow, 0);
    ts_ready = 1'b1;
    wait_until(80);
    pin("s5_p0", 0, 10, 0, 0);
    for (int i = 1; i < 5; i++) pin("s5_p", i, 10 * (i + 1), i, 0);
    chk("s5_popped_n", popped.size(), 5);

    // Asynchronous reset with entries queued
    do_reset();
    pulse_at(10); pulse_at(20); pulse_at(30);
    wait_until(40);
    chk("s6_queued", ts_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_valid", ts_valid, 0);
    chk("s6_rst_lock",  locked, 0);
    chk("s6_rst_now",   time_now, 0);
    chk("s6_rst_index", ts_index, 0);
    tick();
    tick();
    rst_n = 1'b1;
    pulse_at(20);
    wait_until(22);
    chk("s6_valid", ts_valid, 1);
    chk("s6_time",  ts_time, 20);
    chk("s6_index", ts_index, 0);
    chk("s6_ok",    ts_period_ok, 0);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
